// File: rtl/call_stack_ctl_pkg.sv
// Shared constants and the checkpoint record for the return-address stack.
// The record widths follow the default DEPTH / IP_WIDTH.
package call_stack_ctl_pkg;

    localparam int DEFAULT_DEPTH    = 16;
    localparam int DEFAULT_NCKPT    = 8;
    localparam int DEFAULT_IP_WIDTH = 48;

    localparam int DEFAULT_PTR_W = $clog2(DEFAULT_DEPTH);
    localparam int DEFAULT_CNT_W = DEFAULT_PTR_W + 1;

    // Everything needed to rebuild the speculative stack top after a flush.
    typedef struct packed {
        logic [DEFAULT_PTR_W-1:0]    tos;
        logic [DEFAULT_CNT_W-1:0]    depth_cnt;
        logic [DEFAULT_IP_WIDTH-1:0] top_addr;
    } ckpt_rec_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } stack_op_e;

endpackage

// File: rtl/call_stack_ckpt_q.sv
// Circular checkpoint queue: allocate at tail, retire at head, truncate on restore.
// Misuse checks are compiled in when CALL_STACK_ASSERT_ON is defined.
module call_stack_ckpt_q #(
    parameter int NCKPT = 8,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc,
    input  logic [W-1:0]             alloc_data,
    input  logic                     retire,
    input  logic                     restore,
    input  logic [$clog2(NCKPT)-1:0] restore_id,
    output logic [$clog2(NCKPT)-1:0] alloc_id,
    output logic                     full,
    output logic [W-1:0]             restore_data
);

    localparam int ID_W = $clog2(NCKPT);
    localparam logic [ID_W:0] PTR_FULL = (ID_W+1)'(NCKPT);
    localparam logic [ID_W:0] PTR_ONE  = (ID_W+1)'(1);

    logic [ID_W:0]   head_q, head_d;
    logic [ID_W:0]   tail_q, tail_d;
    logic [ID_W-1:0] restore_off;
    logic            empty;
    logic            slot_we;
    logic [W-1:0]    slot_mem [NCKPT];

    assign full         = (tail_q - head_q) == PTR_FULL;
    assign empty        = tail_q == head_q;
    assign alloc_id     = tail_q[ID_W-1:0];
    assign restore_data = slot_mem[restore_id];
    // Age of the restored slot relative to head recovers the wrap bit of the new tail.
    assign restore_off  = restore_id - head_q[ID_W-1:0];

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        head_d  = head_q;
        tail_d  = tail_q;
        slot_we = 1'b0;
        if (restore) begin
            tail_d = head_q + {1'b0, restore_off} + PTR_ONE;
        end else if (alloc && !full) begin
            slot_we = 1'b1;
            tail_d  = tail_q + PTR_ONE;
        end
        if (retire && !empty) begin
            head_d = head_q + PTR_ONE;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // NOTE: slot storage is deliberately not reset; the pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        if (slot_we) begin
            slot_mem[tail_q[ID_W-1:0]] <= alloc_data;
        end
    end

`ifdef CALL_STACK_ASSERT_ON
    always @(posedge clk) begin
        if (rst) begin
            assert (!(alloc && full && !restore));
            assert (!(retire && empty));
        end
    end
`endif

endmodule

// File: rtl/call_stack_ctl.sv
// Return-address stack with per-branch checkpoint/restore, one per thread.
// Define CALL_STACK_STATS_EN to add saturating overflow/underflow counters.
module call_stack_ctl
    import call_stack_ctl_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int IP_WIDTH = DEFAULT_IP_WIDTH,
    parameter int NCKPT    = DEFAULT_NCKPT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_en,
    input  logic [IP_WIDTH-1:0]      push_addr,
    input  logic                     pop_en,
    output logic                     pop_valid,
    output logic [IP_WIDTH-1:0]      pop_addr,
    input  logic                     ckpt_alloc,
    output logic [$clog2(NCKPT)-1:0] ckpt_id,
    output logic                     ckpt_full,
    input  logic                     restore_en,
    input  logic [$clog2(NCKPT)-1:0] restore_id,
    input  logic                     retire_en,
`ifdef CALL_STACK_STATS_EN
    output logic [15:0]              ovf_cnt,
    output logic [15:0]              unf_cnt,
`endif
    output logic [$clog2(DEPTH):0]   depth_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [PTR_W-1:0]    tos_q, tos_d, top_idx;
    logic [CNT_W-1:0]    depth_q, depth_d;
    logic                stack_empty;
    stack_op_e           op;

    logic [IP_WIDTH-1:0] entry_mem [DEPTH];
    logic                mem_we;
    logic [PTR_W-1:0]    mem_waddr;
    logic [IP_WIDTH-1:0] mem_wdata;

    ckpt_rec_t           save_rec;
    ckpt_rec_t           restore_rec;

    assign top_idx     = tos_q - PTR_ONE;
    assign stack_empty = depth_q == '0;
    assign pop_valid   = !stack_empty;
    assign pop_addr    = stack_empty ? '0 : entry_mem[top_idx];
    assign depth_cnt   = depth_q;

    // A simultaneous push+pop on an empty stack degenerates to a plain push.
    always_comb begin
        op = OP_NONE;
        if (!restore_en) begin
            if (push_en && pop_en) begin
                op = stack_empty ? OP_PUSH : OP_REPLACE;
            end else if (push_en) begin
                op = OP_PUSH;
            end else if (pop_en && !stack_empty) begin
                op = OP_POP;
            end
        end
    end

    always_comb begin
        tos_d     = tos_q;
        depth_d   = depth_q;
        mem_we    = 1'b0;
        mem_waddr = tos_q;
        mem_wdata = push_addr;
        if (restore_en) begin
            tos_d     = restore_rec.tos;
            depth_d   = restore_rec.depth_cnt;
            mem_we    = 1'b1;
            mem_waddr = restore_rec.tos - PTR_ONE;
            mem_wdata = restore_rec.top_addr;
        end else begin
            case (op)
                OP_PUSH: begin
                    // At full depth the write lands on the oldest slot; depth just stays saturated.
                    mem_we = 1'b1;
                    tos_d  = tos_q + PTR_ONE;
                    if (depth_q != FULL_DEPTH) begin
                        depth_d = depth_q + CNT_ONE;
                    end
                end
                OP_POP: begin
                    tos_d   = top_idx;
                    depth_d = depth_q - CNT_ONE;
                end
                OP_REPLACE: begin
                    mem_we    = 1'b1;
                    mem_waddr = top_idx;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tos_q   <= '0;
            depth_q <= '0;
        end else begin
            tos_q   <= tos_d;
            depth_q <= depth_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            entry_mem[mem_waddr] <= mem_wdata;
        end
    end

    // The checkpoint captures the state as it stood before this cycle's push/pop.
    always_comb begin
        save_rec           = '0;
        save_rec.tos       = tos_q;
        save_rec.depth_cnt = depth_q;
        save_rec.top_addr  = entry_mem[top_idx];
    end

    call_stack_ckpt_q #(
        .NCKPT (NCKPT),
        .W     ($bits(ckpt_rec_t))
    ) u_ckpt_q (
        .clk          (clk),
        .rst          (rst),
        .alloc        (ckpt_alloc),
        .alloc_data   (save_rec),
        .retire       (retire_en),
        .restore      (restore_en),
        .restore_id   (restore_id),
        .alloc_id     (ckpt_id),
        .full         (ckpt_full),
        .restore_data (restore_rec)
    );

`ifdef CALL_STACK_STATS_EN
    logic [15:0] ovf_q, ovf_d;
    logic [15:0] unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (!restore_en && push_en && !pop_en && depth_q == FULL_DEPTH && ovf_q != '1) begin
            ovf_d = ovf_q + 16'd1;
        end
        if (!restore_en && pop_en && stack_empty && unf_q != '1) begin
            unf_d = unf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf_cnt = ovf_q;
    assign unf_cnt = unf_q;
`endif

endmodule

// File: tb/tb_call_stack_ctl.sv
// Directed scenarios plus randomized traffic against a queue/array reference model.
module tb_call_stack_ctl;

    localparam int DEPTH = 16;
    localparam int NCKPT = 8;
    localparam int IPW   = 48;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           push_en = 1'b0, pop_en = 1'b0;
    logic           ckpt_alloc = 1'b0, restore_en = 1'b0, retire_en = 1'b0;
    logic [IPW-1:0] push_addr = '0;
    logic [2:0]     restore_id = '0;
    logic           pop_valid, ckpt_full;
    logic [IPW-1:0] pop_addr;
    logic [2:0]     ckpt_id;
    logic [4:0]     depth_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    call_stack_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .push_en    (push_en),
        .push_addr  (push_addr),
        .pop_en     (pop_en),
        .pop_valid  (pop_valid),
        .pop_addr   (pop_addr),
        .ckpt_alloc (ckpt_alloc),
        .ckpt_id    (ckpt_id),
        .ckpt_full  (ckpt_full),
        .restore_en (restore_en),
        .restore_id (restore_id),
        .retire_en  (retire_en),
        .depth_cnt  (depth_cnt)
    );

    // Reference model: circular array of return addresses plus a queue of checkpoints.
    typedef struct {
        int             id;
        int             tos;
        int             depth;
        logic [IPW-1:0] top;
    } ck_t;

    logic [IPW-1:0] m_mem [DEPTH];
    int             m_tos, m_depth, m_tail;
    ck_t            m_ck [$];

    task automatic idle();
        push_en = 0; pop_en = 0; ckpt_alloc = 0; restore_en = 0; retire_en = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        #2;
        @(posedge clk);
        #1;
        rst = 1;
        m_tos = 0; m_depth = 0; m_tail = 0;
        m_ck.delete();
    endtask

    task automatic model_step();
        bit retire_ok;
        retire_ok = m_ck.size() > 0;
        if (restore_en) begin
            int k;
            ck_t r;
            k = -1;
            foreach (m_ck[i]) if (m_ck[i].id == int'(restore_id)) k = i;
            if (k >= 0) begin
                r = m_ck[k];
                while (m_ck.size() > k + 1) void'(m_ck.pop_back());
                m_tail  = (r.id + 1) % NCKPT;
                m_tos   = r.tos;
                m_depth = r.depth;
                m_mem[(r.tos + DEPTH - 1) % DEPTH] = r.top;
            end
        end else begin
            if (ckpt_alloc && m_ck.size() < NCKPT) begin
                m_ck.push_back('{m_tail, m_tos, m_depth, m_mem[(m_tos + DEPTH - 1) % DEPTH]});
                m_tail = (m_tail + 1) % NCKPT;
            end
            if (push_en && pop_en && m_depth > 0) begin
                m_mem[(m_tos + DEPTH - 1) % DEPTH] = push_addr;
            end else if (push_en) begin
                m_mem[m_tos] = push_addr;
                m_tos = (m_tos + 1) % DEPTH;
                if (m_depth < DEPTH) m_depth++;
            end else if (pop_en && m_depth > 0) begin
                m_tos = (m_tos + DEPTH - 1) % DEPTH;
                m_depth--;
            end
        end
        if (retire_en && retire_ok) void'(m_ck.pop_front());
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (depth_cnt !== 5'd0) begin bad++; $display("FAIL reset_depth got=%0d want=0", depth_cnt); end
        total++; if (pop_valid !== 1'b0) begin bad++; $display("FAIL reset_pop_valid got=%b want=0", pop_valid); end
        total++; if (pop_addr !== '0) begin bad++; $display("FAIL reset_pop_addr got=%h want=0", pop_addr); end
        total++; if (ckpt_full !== 1'b0) begin bad++; $display("FAIL reset_ckpt_full got=%b want=0", ckpt_full); end
        total++; if (ckpt_id !== 3'd0) begin bad++; $display("FAIL reset_ckpt_id got=%0d want=0", ckpt_id); end
    endtask

    task automatic test_push_pop();
        do_reset();
        push_en = 1; push_addr = 48'h1000; tick();
        push_addr = 48'h2000; tick();
        push_en = 0; pop_en = 1; #1;
        total++; if (pop_valid !== 1'b1 || pop_addr !== 48'h2000) begin bad++; $display("FAIL pop1 got=%b/%h want=1/2000", pop_valid, pop_addr); end
        tick();
        total++; if (pop_valid !== 1'b1 || pop_addr !== 48'h1000) begin bad++; $display("FAIL pop2 got=%b/%h want=1/1000", pop_valid, pop_addr); end
        tick();
        total++; if (pop_valid !== 1'b0 || depth_cnt !== 5'd0) begin bad++; $display("FAIL pop3_underflow got=%b/%0d want=0/0", pop_valid, depth_cnt); end
        tick();
        idle(); #1;
        total++; if (depth_cnt !== 5'd0) begin bad++; $display("FAIL underflow_hold got=%0d want=0", depth_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        push_en = 1;
        for (int i = 1; i <= 17; i++) begin
            push_addr = IPW'(i);
            tick();
        end
        push_en = 0; #1;
        total++; if (depth_cnt !== 5'd16) begin bad++; $display("FAIL wrap_depth got=%0d want=16", depth_cnt); end
        pop_en = 1;
        for (int i = 0; i < 16; i++) begin
            #1;
            total++; if (pop_valid !== 1'b1 || pop_addr !== IPW'(17 - i)) begin bad++; $display("FAIL wrap_pop%0d got=%b/%0d want=1/%0d", i, pop_valid, pop_addr, 17 - i); end
            tick();
        end
        #1;
        total++; if (pop_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%b want=0", pop_valid); end
        idle();
    endtask

    task automatic test_push_pop_same();
        do_reset();
        push_en = 1; push_addr = 48'hA; tick();
        pop_en = 1; push_addr = 48'hB; #1;
        total++; if (pop_addr !== 48'hA) begin bad++; $display("FAIL same_cycle_pop got=%h want=a", pop_addr); end
        tick();
        idle(); #1;
        total++; if (pop_addr !== 48'hB || depth_cnt !== 5'd1) begin bad++; $display("FAIL same_cycle_after got=%h/%0d want=b/1", pop_addr, depth_cnt); end
    endtask

    task automatic test_restore();
        do_reset();
        push_en = 1; push_addr = 48'hA; tick();
        push_en = 0; ckpt_alloc = 1; #1;
        total++; if (ckpt_id !== 3'd0) begin bad++; $display("FAIL restore_alloc_id got=%0d want=0", ckpt_id); end
        tick();
        ckpt_alloc = 0; pop_en = 1; tick();
        pop_en = 0; push_en = 1; push_addr = 48'hC; tick();
        push_addr = 48'hD; tick();
        push_en = 0; restore_en = 1; restore_id = 3'd0; tick();
        idle(); #1;
        total++; if (pop_addr !== 48'hA || pop_valid !== 1'b1) begin bad++; $display("FAIL restore_top got=%b/%h want=1/a", pop_valid, pop_addr); end
        total++; if (depth_cnt !== 5'd1) begin bad++; $display("FAIL restore_depth got=%0d want=1", depth_cnt); end
        total++; if (ckpt_id !== 3'd1) begin bad++; $display("FAIL restore_tail got=%0d want=1", ckpt_id); end
    endtask

    task automatic test_ckpt_full();
        do_reset();
        ckpt_alloc = 1;
        for (int i = 0; i < NCKPT; i++) begin
            #1;
            total++; if (ckpt_id !== 3'(i) || ckpt_full !== 1'b0) begin bad++; $display("FAIL alloc%0d got=%0d/%b want=%0d/0", i, ckpt_id, ckpt_full, i); end
            tick();
        end
        #1;
        total++; if (ckpt_full !== 1'b1) begin bad++; $display("FAIL ckpt_full got=%b want=1", ckpt_full); end
        tick();
        ckpt_alloc = 0; #1;
        total++; if (ckpt_full !== 1'b1 || ckpt_id !== 3'd0) begin bad++; $display("FAIL ninth_alloc got=%b/%0d want=1/0", ckpt_full, ckpt_id); end
        retire_en = 1; tick();
        retire_en = 0; #1;
        total++; if (ckpt_full !== 1'b0) begin bad++; $display("FAIL retire_unfull got=%b want=0", ckpt_full); end
        ckpt_alloc = 1; tick();
        ckpt_alloc = 0; #1;
        total++; if (ckpt_full !== 1'b1 || ckpt_id !== 3'd1) begin bad++; $display("FAIL refill got=%b/%0d want=1/1", ckpt_full, ckpt_id); end
    endtask

    task automatic test_async_reset();
        do_reset();
        push_en = 1;
        for (int i = 0; i < 5; i++) begin
            push_addr = IPW'(48'h100 + i);
            tick();
        end
        push_en = 0; #1;
        total++; if (depth_cnt !== 5'd5) begin bad++; $display("FAIL pre_reset_depth got=%0d want=5", depth_cnt); end
        #1 rst = 0;
        #1;
        total++; if (depth_cnt !== 5'd0 || pop_valid !== 1'b0) begin bad++; $display("FAIL async_reset got=%0d/%b want=0/0", depth_cnt, pop_valid); end
        @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic test_random();
        int fails_before;
        do_reset();
        fails_before = bad;
        for (int c = 0; c < 2000; c++) begin
            idle();
            push_en   = ($urandom_range(0, 99) < 40);
            pop_en    = ($urandom_range(0, 99) < 40);
            push_addr = IPW'({$urandom(), $urandom()});
            if (m_ck.size() < NCKPT) ckpt_alloc = ($urandom_range(0, 99) < 25);
            if (m_ck.size() > 0) begin
                retire_en = ($urandom_range(0, 99) < 15);
                if ($urandom_range(0, 99) < 6) begin
                    restore_en = 1;
                    restore_id = 3'(m_ck[$urandom_range(0, m_ck.size() - 1)].id);
                end
            end
            #1;
            if (bad - fails_before < 20) begin
                total++; if (pop_valid !== (m_depth != 0)) begin bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, pop_valid, m_depth != 0); end
                total++; if (pop_addr !== ((m_depth != 0) ? m_mem[(m_tos + DEPTH - 1) % DEPTH] : '0)) begin bad++; $display("FAIL rnd_addr c=%0d got=%h", c, pop_addr); end
                total++; if (depth_cnt !== 5'(m_depth)) begin bad++; $display("FAIL rnd_depth c=%0d got=%0d want=%0d", c, depth_cnt, m_depth); end
                total++; if (ckpt_full !== (m_ck.size() == NCKPT)) begin bad++; $display("FAIL rnd_full c=%0d got=%b want=%b", c, ckpt_full, m_ck.size() == NCKPT); end
                total++; if (ckpt_id !== 3'(m_tail)) begin bad++; $display("FAIL rnd_ckpt_id c=%0d got=%0d want=%0d", c, ckpt_id, m_tail); end
            end
            model_step();
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_wrap();
        test_push_pop_same();
        test_restore();
        test_ckpt_full();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
